wb_store_buffer: RTL and testbench



---
 rtl/wb_store_buffer_pkg.sv | 23 ++
 rtl/wb_store_buffer_if.sv | 43 ++++
 rtl/wb_store_buffer_line_match.sv | 27 ++
 rtl/wb_store_buffer.sv | 108 ++++++++++
 tb/tb_wb_store_buffer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_store_buffer_pkg.sv
// Shared definitions for the writeback store buffer: default geometry,
// store size encoding and the buffered entry layout.
package sb_pkg;

    localparam int unsigned SB_DEPTH  = 4;
    localparam int unsigned SB_ADDR_W = 32;
    localparam int unsigned SB_DATA_W = 64;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_WORD  = 2'b01,
        SZ_DWORD = 2'b10,
        SZ_QWORD = 2'b11
    } sb_size_e;

    // One posted store as held in the buffer.
    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        sb_size_e             size;
    } sb_entry_t;

endpackage

// File: rtl/wb_store_buffer_if.sv
// Bundle of the writeback, dcache-write and load-lookup signals of the store buffer.
// slave: the store buffer itself; master: the surrounding pipeline / dcache.
interface wb_store_buffer_if #(
    parameter int unsigned ADDR_W = sb_pkg::SB_ADDR_W,
    parameter int unsigned DATA_W = sb_pkg::SB_DATA_W
);

    // Writeback side
    logic              WB_Final_Dcache_Write;
    logic [ADDR_W-1:0] WB_Final_Dcache_Address;
    logic [DATA_W-1:0] WB_Final_Dcache_Data;
    logic [1:0]        WB_Final_datasize;
    logic              In_write_ready;

    // Dcache write port side
    logic              SB_DC_WR_V;
    logic [ADDR_W-1:0] SB_DC_WR_ADDR;
    logic [DATA_W-1:0] SB_DC_WR_DATA;
    logic [1:0]        SB_DC_WR_SIZE;
    logic              DC_SB_WR_ACK;

    // Memory-stage load hazard lookup
    logic              MEM_LD_V;
    logic [ADDR_W-1:0] MEM_LD_ADDR;
    logic              SB_LD_HIT;

    logic              SB_EMPTY;

    modport slave (
        input  WB_Final_Dcache_Write, WB_Final_Dcache_Address, WB_Final_Dcache_Data,
        input  WB_Final_datasize, DC_SB_WR_ACK, MEM_LD_V, MEM_LD_ADDR,
        output In_write_ready, SB_DC_WR_V, SB_DC_WR_ADDR, SB_DC_WR_DATA, SB_DC_WR_SIZE,
        output SB_LD_HIT, SB_EMPTY
    );

    modport master (
        output WB_Final_Dcache_Write, WB_Final_Dcache_Address, WB_Final_Dcache_Data,
        output WB_Final_datasize, DC_SB_WR_ACK, MEM_LD_V, MEM_LD_ADDR,
        input  In_write_ready, SB_DC_WR_V, SB_DC_WR_ADDR, SB_DC_WR_DATA, SB_DC_WR_SIZE,
        input  SB_LD_HIT, SB_EMPTY
    );

endinterface

// File: rtl/wb_store_buffer_line_match.sv
// DEPTH-way 8-byte line comparator: flags a load whose line matches any valid pending store.
module sb_line_match #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                         i_ld_v,
    input  logic [ADDR_W-1:0]            i_ld_addr,
    input  logic [DEPTH-1:0]             i_valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] i_addr,
    output logic                         o_hit
);

    logic [DEPTH-1:0] w_match;
    logic             w_unused_low;

    // Per-entry line compare; byte offset within the line is ignored.
    always_comb begin
        w_match      = '0;
        w_unused_low = ^i_ld_addr[2:0];
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_match[i]   = i_valid[i] && (i_addr[i][ADDR_W-1:3] == i_ld_addr[ADDR_W-1:3]);
            w_unused_low = w_unused_low ^ (^i_addr[i][2:0]);
        end
        o_hit = i_ld_v & (|w_match);
    end

endmodule

// File: rtl/wb_store_buffer.sv
// Posted-write FIFO between writeback and the dcache write port, with a
// combinational load-vs-pending-store line hazard check.
module wb_store_buffer
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH  = SB_DEPTH,
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W
) (
    input logic              CLK,
    input logic              CLR,
    wb_store_buffer_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]            r_head;
    logic [PTR_W-1:0]            r_tail;
    logic [CNT_W-1:0]            r_count;
    logic [CNT_W-1:0]            w_count_nxt;
    logic [DEPTH-1:0]            r_valid;
    sb_entry_t                   r_mem [DEPTH];

    logic                        w_ready;
    logic                        w_head_v;
    logic                        w_enq;
    logic                        w_deq;
    logic [DEPTH-1:0][ADDR_W-1:0] w_addrs;
    logic [DATA_W-1:0]           w_head_data;

    // Ready depends only on registered count, so an ack never feeds back into ready.
    assign w_ready  = (r_count != CNT_W'(DEPTH));
    assign w_head_v = (r_count != '0);
    assign w_enq    = bus.WB_Final_Dcache_Write & w_ready;
    assign w_deq    = w_head_v & bus.DC_SB_WR_ACK;

    assign w_head_data = r_mem[r_head].data;

    assign bus.In_write_ready = w_ready;
    assign bus.SB_DC_WR_V     = w_head_v;
    assign bus.SB_DC_WR_ADDR  = r_mem[r_head].addr;
    assign bus.SB_DC_WR_DATA  = w_head_data;
    assign bus.SB_DC_WR_SIZE  = r_mem[r_head].size;
    assign bus.SB_EMPTY       = ~w_head_v;

    // Occupancy next state: simultaneous enqueue and dequeue leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers and occupancy; power-of-two depth makes the wrap a natural overflow.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + PTR_W'(1);
            if (w_deq) r_head <= r_head + PTR_W'(1);
            r_count <= w_count_nxt;
        end
    end

    // Per-entry valid bits feeding the hazard check.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_valid <= '0;
        end else begin
            if (w_enq) r_valid[r_tail] <= 1'b1;
            if (w_deq) r_valid[r_head] <= 1'b0;
        end
    end

    // Entry storage is not reset; valid bits and count qualify every use.
    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_mem[r_tail] <= '{addr: bus.WB_Final_Dcache_Address,
                               data: bus.WB_Final_Dcache_Data,
                               size: sb_size_e'(bus.WB_Final_datasize)};
        end
    end

    // Flatten stored addresses for the comparator.
    always_comb begin
        w_addrs = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_addrs[i] = r_mem[i].addr;
        end
    end

    sb_line_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_line_match (
        .i_ld_v    (bus.MEM_LD_V),
        .i_ld_addr (bus.MEM_LD_ADDR),
        .i_valid   (r_valid),
        .i_addr    (w_addrs),
        .o_hit     (bus.SB_LD_HIT)
    );

endmodule

// File: tb/tb_wb_store_buffer.sv
// Self-checking bench for wb_store_buffer: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_wb_store_buffer;
    import sb_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 64;

    logic clk;
    logic clr;

    wb_store_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    wb_store_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
    } st_t;

    st_t         m_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    logic        d_wr, d_ack, d_ldv;
    logic [31:0] d_addr, d_ld;
    logic [63:0] d_data;
    logic [1:0]  d_size;

    // Apply one cycle's inputs (called just after a falling edge) and let outputs settle.
    task automatic drive(input logic wr, input logic [31:0] a, input logic [63:0] d,
                         input logic [1:0] s, input logic ack, input logic ldv,
                         input logic [31:0] ld);
        d_wr = wr; d_addr = a; d_data = d; d_size = s; d_ack = ack; d_ldv = ldv; d_ld = ld;
        bus.WB_Final_Dcache_Write   = wr;
        bus.WB_Final_Dcache_Address = a;
        bus.WB_Final_Dcache_Data    = d;
        bus.WB_Final_datasize       = s;
        bus.DC_SB_WR_ACK            = ack;
        bus.MEM_LD_V                = ldv;
        bus.MEM_LD_ADDR             = ld;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    endtask

    // Reference model: a bounded in-order queue; stores overlapping the load line hit.
    function automatic logic m_hit();
        if (!d_ldv) return 1'b0;
        foreach (m_q[i]) if (m_q[i].addr[31:3] == d_ld[31:3]) return 1'b1;
        return 1'b0;
    endfunction

    // Advance one clock, updating the model with the inputs presented this cycle.
    task automatic step();
        logic acc;
        if (clr) begin
            m_q.delete();
        end else begin
            acc = d_wr && (m_q.size() < DEPTH);
            if (d_ack && m_q.size() > 0) m_q.delete(0);
            if (acc) m_q.push_back('{addr: d_addr, data: d_data, size: d_size});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        clr = 1'b1;
        idle();
        @(negedge clk);
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b1, 32'h0);
        n_checks++; if (bus.In_write_ready !== 1'b1) begin n_errors++;
            $display("FAIL reset_ready: got %0b expected 1", bus.In_write_ready); end
        n_checks++; if (bus.SB_DC_WR_V !== 1'b0) begin n_errors++;
            $display("FAIL reset_wr_v: got %0b expected 0", bus.SB_DC_WR_V); end
        n_checks++; if (bus.SB_LD_HIT !== 1'b0) begin n_errors++;
            $display("FAIL reset_hit: got %0b expected 0", bus.SB_LD_HIT); end
        n_checks++; if (bus.SB_EMPTY !== 1'b1) begin n_errors++;
            $display("FAIL reset_empty: got %0b expected 1", bus.SB_EMPTY); end
        clr = 1'b0;
        m_q.delete();
        idle();
    endtask

    task automatic test_single();
        drive(1'b1, 32'h1000, 64'hDEADBEEF, SZ_WORD, 1'b0, 1'b0, 32'h0);
        n_checks++; if (bus.SB_DC_WR_V !== 1'b0) begin n_errors++;
            $display("FAIL single_v_before: got %0b expected 0", bus.SB_DC_WR_V); end
        step();
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b0, 32'h0);
        n_checks++; if (bus.SB_DC_WR_V !== 1'b1) begin n_errors++;
            $display("FAIL single_v: got %0b expected 1", bus.SB_DC_WR_V); end
        n_checks++; if (bus.SB_DC_WR_ADDR !== 32'h1000) begin n_errors++;
            $display("FAIL single_addr: got %h expected 00001000", bus.SB_DC_WR_ADDR); end
        n_checks++; if (bus.SB_DC_WR_DATA !== 64'hDEADBEEF) begin n_errors++;
            $display("FAIL single_data: got %h expected deadbeef", bus.SB_DC_WR_DATA); end
        n_checks++; if (bus.SB_DC_WR_SIZE !== SZ_WORD) begin n_errors++;
            $display("FAIL single_size: got %b expected 01", bus.SB_DC_WR_SIZE); end
        n_checks++; if (bus.SB_EMPTY !== 1'b0) begin n_errors++;
            $display("FAIL single_not_empty: got %0b expected 0", bus.SB_EMPTY); end
        step();
        idle();
        n_checks++; if (bus.SB_EMPTY !== 1'b1) begin n_errors++;
            $display("FAIL single_empty_after_ack: got %0b expected 1", bus.SB_EMPTY); end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h100 + 32'(8 * k), 64'h100 + 64'(k), SZ_DWORD, 1'b0, 1'b0, 32'h0);
            n_checks++; if (bus.In_write_ready !== 1'b1) begin n_errors++;
                $display("FAIL full_ready_%0d: got %0b expected 1", k, bus.In_write_ready); end
            step();
        end
        // Fifth request while full must be dropped.
        drive(1'b1, 32'h5555, 64'h5555, SZ_DWORD, 1'b0, 1'b0, 32'h0);
        n_checks++; if (bus.In_write_ready !== 1'b0) begin n_errors++;
            $display("FAIL full_not_ready: got %0b expected 0", bus.In_write_ready); end
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b0, 32'h0);
            n_checks++; if (bus.SB_DC_WR_DATA !== 64'h100 + 64'(k)) begin n_errors++;
                $display("FAIL full_order_%0d: got %h expected %h", k, bus.SB_DC_WR_DATA,
                         64'h100 + 64'(k)); end
            step();
            if (k == 0) begin
                n_checks++; if (bus.In_write_ready !== 1'b1) begin n_errors++;
                    $display("FAIL full_ready_after_ack: got %0b expected 1",
                             bus.In_write_ready); end
            end
        end
        idle();
        n_checks++; if (bus.SB_EMPTY !== 1'b1) begin n_errors++;
            $display("FAIL full_drained: got %0b expected 1", bus.SB_EMPTY); end
    endtask

    task automatic test_full_ack_write();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h200 + 32'(8 * k), 64'hA0 + 64'(k), SZ_QWORD, 1'b0, 1'b0, 32'h0);
            step();
        end
        drive(1'b1, 32'h240, 64'hA4, SZ_QWORD, 1'b1, 1'b0, 32'h0);
        n_checks++; if (bus.In_write_ready !== 1'b0) begin n_errors++;
            $display("FAIL faw_ready_full: got %0b expected 0", bus.In_write_ready); end
        step();
        idle();
        n_checks++; if (bus.In_write_ready !== 1'b1) begin n_errors++;
            $display("FAIL faw_count3_ready: got %0b expected 1", bus.In_write_ready); end
        drive(1'b1, 32'h248, 64'hA5, SZ_QWORD, 1'b0, 1'b0, 32'h0);
        step();
        idle();
        n_checks++; if (bus.In_write_ready !== 1'b0) begin n_errors++;
            $display("FAIL faw_count4_ready: got %0b expected 0", bus.In_write_ready); end
        for (int k = 0; k < 4; k++) begin
            logic [63:0] exp_d;
            exp_d = (k == 3) ? 64'hA5 : 64'hA1 + 64'(k);
            drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b0, 32'h0);
            n_checks++; if (bus.SB_DC_WR_DATA !== exp_d) begin n_errors++;
                $display("FAIL faw_order_%0d: got %h expected %h", k, bus.SB_DC_WR_DATA,
                         exp_d); end
            step();
        end
        idle();
    endtask

    task automatic test_hazard();
        drive(1'b1, 32'h2004, 64'h77, SZ_WORD, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b1, 32'h2000);
        n_checks++; if (bus.SB_LD_HIT !== 1'b1) begin n_errors++;
            $display("FAIL hz_same_line: got %0b expected 1", bus.SB_LD_HIT); end
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b1, 32'h2008);
        n_checks++; if (bus.SB_LD_HIT !== 1'b0) begin n_errors++;
            $display("FAIL hz_next_line: got %0b expected 0", bus.SB_LD_HIT); end
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0, 32'h2000);
        n_checks++; if (bus.SB_LD_HIT !== 1'b0) begin n_errors++;
            $display("FAIL hz_ld_invalid: got %0b expected 0", bus.SB_LD_HIT); end
        // A store entering this cycle is not yet visible.
        drive(1'b1, 32'h3000, 64'h88, SZ_WORD, 1'b0, 1'b1, 32'h3003);
        n_checks++; if (bus.SB_LD_HIT !== 1'b0) begin n_errors++;
            $display("FAIL hz_enq_invisible: got %0b expected 0", bus.SB_LD_HIT); end
        step();
        // A store being acked this cycle is still visible.
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b1, 32'h2007);
        n_checks++; if (bus.SB_LD_HIT !== 1'b1) begin n_errors++;
            $display("FAIL hz_ack_visible: got %0b expected 1", bus.SB_LD_HIT); end
        step();
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b1, 32'h2000);
        n_checks++; if (bus.SB_LD_HIT !== 1'b0) begin n_errors++;
            $display("FAIL hz_after_drain: got %0b expected 0", bus.SB_LD_HIT); end
        step();
        idle();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h400, 64'hB0, SZ_DWORD, 1'b0, 1'b0, 32'h0);
        step();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h400 + 32'(8 * (k + 1)), 64'hB1 + 64'(k), SZ_DWORD, 1'b1,
                  1'b0, 32'h0);
            n_checks++; if (bus.SB_DC_WR_V !== 1'b1 || bus.In_write_ready !== 1'b1 ||
                            bus.SB_DC_WR_DATA !== 64'hB0 + 64'(k)) begin n_errors++;
                $display("FAIL b2b_%0d: got v=%0b rdy=%0b data=%h expected v=1 rdy=1 data=%h",
                         k, bus.SB_DC_WR_V, bus.In_write_ready, bus.SB_DC_WR_DATA,
                         64'hB0 + 64'(k)); end
            step();
        end
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b0, 32'h0);
        n_checks++; if (bus.SB_DC_WR_DATA !== 64'hBA) begin n_errors++;
            $display("FAIL b2b_last: got %h expected ba", bus.SB_DC_WR_DATA); end
        step();
        idle();
        n_checks++; if (bus.SB_EMPTY !== 1'b1) begin n_errors++;
            $display("FAIL b2b_empty: got %0b expected 1", bus.SB_EMPTY); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, 32'h6000 + 32'($urandom_range(0, 63)),
                  {$urandom, $urandom}, 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 1) != 0, 32'h6000 + 32'($urandom_range(0, 63)));
            n_checks++; if (bus.In_write_ready !== (m_q.size() < DEPTH)) begin n_errors++;
                $display("FAIL rand_ready cyc %0d: got %0b expected %0b", c,
                         bus.In_write_ready, m_q.size() < DEPTH); end
            n_checks++; if (bus.SB_DC_WR_V !== (m_q.size() != 0)) begin n_errors++;
                $display("FAIL rand_v cyc %0d: got %0b expected %0b", c, bus.SB_DC_WR_V,
                         m_q.size() != 0); end
            n_checks++; if (bus.SB_EMPTY !== (m_q.size() == 0)) begin n_errors++;
                $display("FAIL rand_empty cyc %0d: got %0b expected %0b", c, bus.SB_EMPTY,
                         m_q.size() == 0); end
            n_checks++; if (bus.SB_LD_HIT !== m_hit()) begin n_errors++;
                $display("FAIL rand_hit cyc %0d: got %0b expected %0b", c, bus.SB_LD_HIT,
                         m_hit()); end
            if (m_q.size() != 0) begin
                n_checks++; if (bus.SB_DC_WR_ADDR !== m_q[0].addr ||
                                bus.SB_DC_WR_DATA !== m_q[0].data ||
                                bus.SB_DC_WR_SIZE !== m_q[0].size) begin n_errors++;
                    $display("FAIL rand_head cyc %0d: got %h/%h/%b expected %h/%h/%b", c,
                             bus.SB_DC_WR_ADDR, bus.SB_DC_WR_DATA, bus.SB_DC_WR_SIZE,
                             m_q[0].addr, m_q[0].data, m_q[0].size); end
            end
            step();
        end
        // Drain leftovers so the next scenario starts empty.
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b0, 32'h0);
            step();
        end
        idle();
    endtask

    task automatic test_clr_mid();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h800 + 32'(8 * k), 64'hC0 + 64'(k), SZ_BYTE, 1'b0, 1'b0, 32'h0);
            step();
        end
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b1, 32'h800);
        n_checks++; if (bus.SB_LD_HIT !== 1'b1) begin n_errors++;
            $display("FAIL clr_pre_hit: got %0b expected 1", bus.SB_LD_HIT); end
        clr = 1'b1;
        #1;
        n_checks++; if (bus.SB_DC_WR_V !== 1'b0) begin n_errors++;
            $display("FAIL clr_wr_v: got %0b expected 0", bus.SB_DC_WR_V); end
        n_checks++; if (bus.In_write_ready !== 1'b1) begin n_errors++;
            $display("FAIL clr_ready: got %0b expected 1", bus.In_write_ready); end
        n_checks++; if (bus.SB_LD_HIT !== 1'b0) begin n_errors++;
            $display("FAIL clr_hit: got %0b expected 0", bus.SB_LD_HIT); end
        m_q.delete();
        @(negedge clk);
        clr = 1'b0;
        drive(1'b1, 32'h4000, 64'hC9, SZ_QWORD, 1'b0, 1'b0, 32'h0);
        step();
        idle();
        n_checks++; if (bus.SB_DC_WR_V !== 1'b1 || bus.SB_DC_WR_ADDR !== 32'h4000 ||
                        bus.SB_DC_WR_DATA !== 64'hC9) begin n_errors++;
            $display("FAIL clr_new_store: got v=%0b addr=%h data=%h expected v=1 4000 c9",
                     bus.SB_DC_WR_V, bus.SB_DC_WR_ADDR, bus.SB_DC_WR_DATA); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_full_ack_write();
        test_hazard();
        test_back_to_back();
        test_random();
        test_clr_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
